// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared encodings for the 7-seg scan controller
// Digit selector codes, frame field layout and scan state encoding.
package display_pkg;

  localparam logic [1:0] DIG_LEVEL = 2'd0;
  localparam logic [1:0] DIG_SYMB  = 2'd1;
  localparam logic [1:0] DIG_CONTB = 2'd2;
  localparam logic [1:0] DIG_CONTA = 2'd3;

  localparam int FRAME_W   = 10;
  localparam int CONTA_OFS = 6;
  localparam int CONTA_W   = 4;
  localparam int CONTB_OFS = 4;
  localparam int CONTB_W   = 2;
  localparam int NV_OFS    = 2;
  localparam int NV_W      = 2;
  localparam int LIMP_OFS  = 1;
  localparam int MIST_OFS  = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BLANKING = 2'd1,
    ST_LIT      = 2'd2
  } scan_state_e;

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// rtl/display_scan_ctrl_scan_timer.sv - digit slot counter with clear and wrap pulse
// wrap_o is high in the last cycle of a slot, i.e. the next edge returns the count to 0.
module scan_timer #(
  parameter int SLOT_CYC = 12500,
  parameter int CW       = $clog2(SLOT_CYC)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(SLOT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && !clr_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit 7-seg scan controller with per-frame snapshot handshake
// Optional blink of selected digits when DISPLAY_BLINK_EN is defined.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SLOT_CYC  = 12500,
  parameter int BLANK_CYC = 250
`ifdef DISPLAY_BLINK_EN
  , parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               upd_req_i,
  input  logic [FRAME_W-1:0] frame_d_i,
`ifdef DISPLAY_BLINK_EN
  input  logic [3:0]         blink_mask_i,
`endif
  output logic               upd_ack_o,
  output logic [FRAME_W-1:0] frame_q_o,
  output logic [1:0]         sel_o,
  output logic [3:0]         dig_n_o,
  output logic               blank_o
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  if (BLANK_CYC <= 0 || BLANK_CYC >= SLOT_CYC) begin : g_bad_blank
    $error("BLANK_CYC must satisfy 0 < BLANK_CYC < SLOT_CYC");
  end

  scan_state_e        state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         dig_n_q, dig_n_d;
  logic               blank_q, blank_d;
  logic [FRAME_W-1:0] frame_q;
  logic               ack_q;
  logic               load;
  logic [CW-1:0]      cnt;
  logic               wrap;
  logic               timer_en;
  logic               frame_end;
  logic               suppress;

  assign timer_en  = en_i && (state_q != ST_IDLE);
  assign frame_end = wrap && (sel_q == DIG_CONTA);

  scan_timer #(
    .SLOT_CYC (SLOT_CYC),
    .CW       (CW)
  ) u_scan_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (timer_en),
    .clr_i  (!timer_en),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

`ifdef DISPLAY_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!timer_en) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (frame_end) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = !phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  // A blinked digit simply never leaves BLANKING, so slot timing is untouched.
  assign suppress = phase_q && blink_mask_i[sel_q];
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= DIG_LEVEL;
      dig_n_q <= 4'hF;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dig_n_q <= dig_n_d;
      blank_q <= blank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    load    = 1'b0;
    if (!en_i) begin
      state_d = ST_IDLE;
      sel_d   = DIG_LEVEL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANKING;
          sel_d   = DIG_LEVEL;
          load    = upd_req_i;
        end
        ST_BLANKING: begin
          if (cnt == BLANK_LAST && !suppress) begin
            state_d = ST_LIT;
          end
        end
        ST_LIT: ;
        default: state_d = ST_IDLE;
      endcase
      // Snapshot only at the frame boundary so a displayed frame never tears.
      if (wrap) begin
        state_d = ST_BLANKING;
        sel_d   = sel_q + 2'd1;
        load    = frame_end && upd_req_i;
      end
    end
  end

  always_comb begin
    dig_n_d = 4'hF;
    blank_d = 1'b1;
    if (state_d == ST_LIT) begin
      dig_n_d = ~(4'b0001 << sel_d);
      blank_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= load;
      if (load) begin
        frame_q <= frame_d_i;
      end
    end
  end

  assign upd_ack_o = ack_q;
  assign frame_q_o = frame_q;
  assign sel_o     = sel_q;
  assign dig_n_o   = dig_n_q;
  assign blank_o   = blank_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
// Table-driven scan vectors plus a queue of expected UPD_ACK/FRAME_Q events.
module tb_display_scan_ctrl;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int N     = 196;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       req;
  logic [9:0] fd;
  logic       ack;
  logic [9:0] frame_q;
  logic [1:0] sel;
  logic [3:0] dig_n;
  logic       blank;
`ifdef DISPLAY_BLINK_EN
  logic [3:0] blink_mask = 4'b0001;
`endif

  typedef struct {
    logic       en;
    logic       req;
    logic [9:0] fd;
    logic [3:0] dig;
    logic [1:0] sel;
    logic       blank;
  } vec_t;

  typedef struct {
    logic [9:0] frame;
    int         cyc;
  } sb_t;

  vec_t       vec[N];
  sb_t        sbq[$];
  int         total = 0;
  int         bad = 0;
  logic [9:0] cur_frame;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .SLOT_CYC     (SLOT),
    .BLANK_CYC    (BLANK)
`ifdef DISPLAY_BLINK_EN
    , .BLINK_FRAMES (2)
`endif
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .upd_req_i    (req),
    .frame_d_i    (fd),
`ifdef DISPLAY_BLINK_EN
    .blink_mask_i (blink_mask),
`endif
    .upd_ack_o    (ack),
    .frame_q_o    (frame_q),
    .sel_o        (sel),
    .dig_n_o      (dig_n),
    .blank_o      (blank)
  );

  function automatic void exp_scan(input int c, output logic [3:0] d, output logic [1:0] s,
                                   output logic b);
    int   pos;
    int   slot;
    logic lit;
    logic dark;
    pos  = c % SLOT;
    slot = (c / SLOT) % 4;
    dark = 1'b0;
`ifdef DISPLAY_BLINK_EN
    dark = (((c / (4 * SLOT)) / 2) % 2 == 1) && (slot == 0);
`endif
    lit = (pos >= BLANK) && !dark;
    s   = slot[1:0];
    d   = lit ? ~(4'b0001 << slot) : 4'hF;
    b   = !lit;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cycle(input int c, input logic [3:0] ed, input logic [1:0] es,
                             input logic eb);
    sb_t e;
    chk($sformatf("scan c=%0d {dig,sel,blank}", c), {25'd0, dig_n, sel, blank},
        {25'd0, ed, es, eb});
    if (ack) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL ack_unexpected c=%0d: got ack=1 want ack=0", c);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != c || frame_q !== e.frame) begin
          bad++;
          $display("FAIL ack_event c=%0d: got frame=%0h want frame=%0h at c=%0d",
                   c, frame_q, e.frame, e.cyc);
        end
        cur_frame = e.frame;
      end
    end else if (sbq.size() > 0 && sbq[0].cyc <= c) begin
      total++;
      bad++;
      $display("FAIL ack_missing c=%0d: got ack=0 want ack=1", c);
      e = sbq.pop_front();
      cur_frame = e.frame;
    end
    chk($sformatf("frame_hold c=%0d", c), {22'd0, frame_q}, {22'd0, cur_frame});
  endtask

  initial begin
    logic [3:0] ed;
    logic [1:0] es;
    logic       eb;

    for (int c = 0; c < N; c++) begin
      vec[c].en  = 1'b1;
      vec[c].req = (c >= 5 && c <= 32) || (c >= 40 && c <= 52) || (c >= 100);
      vec[c].fd  = (c < 40) ? 10'h2A5 : (c < 100) ? 10'h155 : (c < 140) ? 10'h0F3 : 10'h3C1;
      exp_scan(c, vec[c].dig, vec[c].sel, vec[c].blank);
    end

    // Reset with EN high, then idle with EN low
    rst = 1'b1; en = 1'b1; req = 1'b0; fd = '0; cur_frame = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dig_n", {28'd0, dig_n}, 32'hF);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_blank", {31'd0, blank}, 32'd1);
    chk("rst_frame_q", {22'd0, frame_q}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    en = 1'b0; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_outputs", {25'd0, dig_n, sel, blank}, {25'd0, 4'hF, 2'd0, 1'b1});
    end

    // Scan, handshake, held-REQ reloads and (optionally) blink
    en = 1'b1; req = 1'b0;
    for (int c = 0; c < N; c++) begin
      tick();
      check_cycle(c, vec[c].dig, vec[c].sel, vec[c].blank);
      en  = vec[c].en;
      req = vec[c].req;
      fd  = vec[c].fd;
      if (en && req && (c % (4 * SLOT)) == (4 * SLOT - 1))
        sbq.push_back('{frame: fd, cyc: c + 1});
    end

    // EN dropped mid-slot with a REQ pending
    en = 1'b0; req = 1'b0;
    tick(); tick();
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c <= 12) exp_scan(c, ed, es, eb);
      else begin ed = 4'hF; es = 2'd0; eb = 1'b1; end
      check_cycle(c, ed, es, eb);
      req = (c >= 5);
      fd  = 10'h111;
      en  = (c < 12);
    end
    req = 1'b0;
    tick();
    chk("sb_empty", sbq.size(), 32'd0);

    // Load straight out of IDLE, then async reset kills the ACK in flight
    en = 1'b1; req = 1'b1; fd = 10'h0AA;
    @(posedge clk);
    #1;
    chk("idle_load_ack", {31'd0, ack}, 32'd1);
    chk("idle_load_frame", {22'd0, frame_q}, 32'h0AA);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {18'd0, dig_n, sel, blank, ack, 1'b0},
        {18'd0, 4'hF, 2'd0, 1'b1, 1'b0, 1'b0});
    chk("async_rst_frame", {22'd0, frame_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0; cur_frame = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      exp_scan(c, ed, es, eb);
      check_cycle(c, ed, es, eb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
